// File: rtl/trace_filter_prog.sv
// Trace qualifier: classifies retired instructions, tracks a programmable tail and
// HPM event increments, and produces a registered drop decision plus kept/dropped stats.
module trace_filter_prog #(
  parameter int unsigned NUM_EVT    = 2,
  parameter int unsigned CNT_WIDTH  = 64,
  parameter int unsigned TAIL_WIDTH = 4,
  parameter int unsigned STAT_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         pc_valid,
  input  logic [31:0]                  next_instr,
  input  logic [NUM_EVT*CNT_WIDTH-1:0] evt_counters,
  input  logic [1:0]                   cfg_mode,
  input  logic [2:0]                   cfg_class_en,
  input  logic [NUM_EVT-1:0]           cfg_evt_en,
  input  logic [TAIL_WIDTH-1:0]        cfg_tail_len,
  input  logic                         cfg_clear,
  output logic                         drop_instr,
  output logic [2:0]                   keep_cause,
  output logic [NUM_EVT-1:0]           evt_cause,
  output logic [STAT_WIDTH-1:0]        kept_count,
  output logic [STAT_WIDTH-1:0]        dropped_count
);

  localparam int unsigned EVT_BUS_W = NUM_EVT * CNT_WIDTH;
  localparam logic [31:0] WFI_INSTR = 32'h1050_0073;
  localparam logic [1:0]  MODE_PASS = 2'b01;
  localparam logic [1:0]  MODE_DROP = 2'b10;
  localparam logic [STAT_WIDTH-1:0] STAT_MAX = '1;

  logic                   drop_instr_q, drop_instr_d;
  logic [2:0]             keep_cause_q, keep_cause_d;
  logic [NUM_EVT-1:0]     evt_cause_q, evt_cause_d;
  logic [STAT_WIDTH-1:0]  kept_count_q, kept_count_d;
  logic [STAT_WIDTH-1:0]  dropped_count_q, dropped_count_d;
  logic [TAIL_WIDTH-1:0]  tail_cnt_q, tail_cnt_d;
  logic [NUM_EVT-1:0]     evt_pend_q, evt_pend_d;
  logic [EVT_BUS_W-1:0]   prev_cnt_q, prev_cnt_d;

  // Instruction classification (32-bit opcodes and RVC quadrants)
  logic [6:0] opcode;
  logic [1:0] quad;
  logic [2:0] c_funct3;
  logic       is_branch, is_jump, is_wfi, class_hit;

  assign opcode   = next_instr[6:0];
  assign quad     = next_instr[1:0];
  assign c_funct3 = next_instr[15:13];

  assign is_branch = (opcode == 7'b1100011)
                   | ((quad == 2'b01) & (next_instr[15:14] == 2'b11));
  assign is_jump   = (opcode == 7'b1101111) | (opcode == 7'b1100111)
                   | ((quad == 2'b01) & ((c_funct3 == 3'b101) | (c_funct3 == 3'b001)))
                   | ((quad == 2'b10) & (c_funct3 == 3'b100)
                      & (next_instr[11:7] != 5'd0) & (next_instr[6:2] == 5'd0));
  assign is_wfi    = (next_instr == WFI_INSTR);
  assign class_hit = |({is_wfi, is_jump, is_branch} & cfg_class_en);

  // Per-channel change detection against last cycle's counter snapshot
  logic [NUM_EVT-1:0] evt_chg;

  always_comb begin
    evt_chg = '0;
    for (int unsigned i = 0; i < NUM_EVT; i++) begin
      evt_chg[i] = cfg_evt_en[i]
                 & (evt_counters[i*CNT_WIDTH +: CNT_WIDTH] != prev_cnt_q[i*CNT_WIDTH +: CNT_WIDTH]);
    end
  end

  logic event_hit, tail_active, keep;

  assign event_hit   = |evt_pend_q;
  assign tail_active = (tail_cnt_q != '0);

  // Next-state: qualification, tail, pending events and statistics
  always_comb begin
    drop_instr_d    = drop_instr_q;
    keep_cause_d    = keep_cause_q;
    evt_cause_d     = evt_cause_q;
    kept_count_d    = kept_count_q;
    dropped_count_d = dropped_count_q;
    tail_cnt_d      = tail_cnt_q;
    evt_pend_d      = evt_pend_q | evt_chg;
    prev_cnt_d      = evt_counters;
    keep            = 1'b0;

    if (pc_valid) begin
      evt_pend_d = evt_chg;

      if ((class_hit | event_hit) && (cfg_tail_len != '0)) begin
        tail_cnt_d = cfg_tail_len;
      end else if (tail_active) begin
        tail_cnt_d = tail_cnt_q - TAIL_WIDTH'(1);
      end

      keep_cause_d = 3'b000;
      evt_cause_d  = '0;
      case (cfg_mode)
        MODE_PASS: keep = 1'b1;
        MODE_DROP: keep = 1'b0;
        default: begin
          keep         = class_hit | tail_active | event_hit;
          keep_cause_d = {event_hit, tail_active, class_hit};
          evt_cause_d  = evt_pend_q;
        end
      endcase
      drop_instr_d = ~keep;

      if (keep) begin
        if (kept_count_q != STAT_MAX) kept_count_d = kept_count_q + STAT_WIDTH'(1);
      end else begin
        if (dropped_count_q != STAT_MAX) dropped_count_d = dropped_count_q + STAT_WIDTH'(1);
      end
    end

    // Clear acts after qualification so a coincident instruction uses pre-clear state
    if (cfg_clear) begin
      tail_cnt_d      = '0;
      evt_pend_d      = '0;
      kept_count_d    = '0;
      dropped_count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      drop_instr_q    <= 1'b1;
      keep_cause_q    <= 3'b000;
      evt_cause_q     <= '0;
      kept_count_q    <= '0;
      dropped_count_q <= '0;
      tail_cnt_q      <= '0;
      evt_pend_q      <= '0;
      prev_cnt_q      <= evt_counters;
    end else begin
      drop_instr_q    <= drop_instr_d;
      keep_cause_q    <= keep_cause_d;
      evt_cause_q     <= evt_cause_d;
      kept_count_q    <= kept_count_d;
      dropped_count_q <= dropped_count_d;
      tail_cnt_q      <= tail_cnt_d;
      evt_pend_q      <= evt_pend_d;
      prev_cnt_q      <= prev_cnt_d;
    end
  end

  assign drop_instr    = drop_instr_q;
  assign keep_cause    = keep_cause_q;
  assign evt_cause     = evt_cause_q;
  assign kept_count    = kept_count_q;
  assign dropped_count = dropped_count_q;

endmodule

// File: tb/tb_trace_filter_prog.sv
// Bench for trace_filter_prog: directed scenarios plus randomized traffic checked
// against a behavioural model of the keep/drop rules.
module tb_trace_filter_prog;

  localparam int unsigned NUM_EVT    = 2;
  localparam int unsigned CNT_WIDTH  = 64;
  localparam int unsigned TAIL_WIDTH = 4;
  localparam int unsigned STAT_WIDTH = 8;
  localparam int          STAT_MAX   = 255;

  localparam logic [31:0] I_BEQ   = 32'h0000_0063;
  localparam logic [31:0] I_ADD   = 32'h0000_0033;
  localparam logic [31:0] I_JAL   = 32'h0000_006f;
  localparam logic [31:0] I_CJ    = 32'h0000_a001;
  localparam logic [31:0] I_CJR   = 32'h0000_8082;
  localparam logic [31:0] I_CJR0  = 32'h0000_8002;
  localparam logic [31:0] I_WFI   = 32'h1050_0073;

  logic                         clk;
  logic                         rst_n;
  logic                         pc_valid;
  logic [31:0]                  next_instr;
  logic [NUM_EVT*CNT_WIDTH-1:0] evt_counters;
  logic [1:0]                   cfg_mode;
  logic [2:0]                   cfg_class_en;
  logic [NUM_EVT-1:0]           cfg_evt_en;
  logic [TAIL_WIDTH-1:0]        cfg_tail_len;
  logic                         cfg_clear;
  logic                         drop_instr;
  logic [2:0]                   keep_cause;
  logic [NUM_EVT-1:0]           evt_cause;
  logic [STAT_WIDTH-1:0]        kept_count;
  logic [STAT_WIDTH-1:0]        dropped_count;

  logic [CNT_WIDTH-1:0] cnt [NUM_EVT];

  trace_filter_prog #(
    .NUM_EVT(NUM_EVT), .CNT_WIDTH(CNT_WIDTH),
    .TAIL_WIDTH(TAIL_WIDTH), .STAT_WIDTH(STAT_WIDTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pc_valid(pc_valid), .next_instr(next_instr),
    .evt_counters(evt_counters), .cfg_mode(cfg_mode), .cfg_class_en(cfg_class_en),
    .cfg_evt_en(cfg_evt_en), .cfg_tail_len(cfg_tail_len), .cfg_clear(cfg_clear),
    .drop_instr(drop_instr), .keep_cause(keep_cause), .evt_cause(evt_cause),
    .kept_count(kept_count), .dropped_count(dropped_count)
  );

  always_comb begin
    for (int i = 0; i < NUM_EVT; i++) evt_counters[i*CNT_WIDTH +: CNT_WIDTH] = cnt[i];
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model state
  int                   m_tail;
  bit [NUM_EVT-1:0]     m_pend;
  logic [CNT_WIDTH-1:0] m_prev [NUM_EVT];
  bit                   e_drop;
  bit [2:0]             e_kc;
  bit [NUM_EVT-1:0]     e_ec;
  int                   e_kept, e_dropped;

  // Returns {wfi, jump, branch} matches for an instruction word
  function automatic bit [2:0] classes(input logic [31:0] w);
    bit br, jp, wf;
    br = 0; jp = 0;
    case (w[1:0])
      2'b11: begin
        br = (w[6:0] == 7'h63);
        jp = (w[6:0] == 7'h6f) || (w[6:0] == 7'h67);
      end
      2'b01: begin
        br = (w[15:13] == 3'd6) || (w[15:13] == 3'd7);
        jp = (w[15:13] == 3'd5) || (w[15:13] == 3'd1);
      end
      2'b10: jp = (w[15:13] == 3'd4) && (w[11:7] != 0) && (w[6:2] == 0);
      default: ;
    endcase
    wf = (w == I_WFI);
    return {wf, jp, br};
  endfunction

  task automatic model_edge();
    bit [NUM_EVT-1:0] chg;
    bit cls, ev, ta, keep;
    if (!rst_n) begin
      m_tail = 0; m_pend = '0;
      e_drop = 1; e_kc = 0; e_ec = '0; e_kept = 0; e_dropped = 0;
    end else begin
      for (int i = 0; i < NUM_EVT; i++) chg[i] = cfg_evt_en[i] && (cnt[i] != m_prev[i]);
      if (pc_valid) begin
        cls = |(classes(next_instr) & cfg_class_en);
        ev  = (m_pend != 0);
        ta  = (m_tail > 0);
        e_kc = 0; e_ec = '0;
        if (cfg_mode == 2'b01) keep = 1;
        else if (cfg_mode == 2'b10) keep = 0;
        else begin
          keep = cls || ta || ev;
          e_kc = {ev, ta, cls};
          e_ec = m_pend;
        end
        e_drop = !keep;
        if (keep) e_kept = (e_kept < STAT_MAX) ? e_kept + 1 : STAT_MAX;
        else e_dropped = (e_dropped < STAT_MAX) ? e_dropped + 1 : STAT_MAX;
        if ((cls || ev) && cfg_tail_len != 0) m_tail = int'(cfg_tail_len);
        else if (m_tail > 0) m_tail = m_tail - 1;
        m_pend = chg;
      end else begin
        m_pend = m_pend | chg;
      end
      if (cfg_clear) begin
        m_tail = 0; m_pend = '0; e_kept = 0; e_dropped = 0;
      end
    end
    for (int i = 0; i < NUM_EVT; i++) m_prev[i] = cnt[i];
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("drop", drop_instr, e_drop);
    check("kept_count", kept_count, e_kept);
    check("dropped_count", dropped_count, e_dropped);
    if (!e_drop) begin
      check("keep_cause", keep_cause, e_kc);
      check("evt_cause", evt_cause, e_ec);
    end
    pc_valid  = 1'b0;
    cfg_clear = 1'b0;
  endtask

  task automatic issue(input logic [31:0] w);
    pc_valid = 1'b1;
    next_instr = w;
    step();
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 9))
      0: w = {w[31:7], 7'h63};
      1: w = {w[31:7], 7'h6f};
      2: w = {w[31:7], 7'h67};
      3: begin w[15:14] = 2'b11; w[1:0] = 2'b01; end
      4: begin w[15:13] = ($urandom_range(0, 1) != 0) ? 3'b101 : 3'b001; w[1:0] = 2'b01; end
      5: begin
        w[15:13] = 3'b100; w[6:2] = 5'd0; w[1:0] = 2'b10;
        if ($urandom_range(0, 2) == 0) w[11:7] = 5'd0;
      end
      6: w = I_WFI;
      7: w = {w[31:7], 7'h33};
      default: ;
    endcase
    return w;
  endfunction

  initial begin
    rst_n = 1'b0; pc_valid = 1'b0; next_instr = '0; cfg_clear = 1'b0;
    cfg_mode = 2'b00; cfg_class_en = 3'b001; cfg_evt_en = '0; cfg_tail_len = 4'd2;
    for (int i = 0; i < NUM_EVT; i++) cnt[i] = {$urandom, $urandom};
    idle(2);
    check("rst_drop", drop_instr, 1'b1);
    check("rst_kept", kept_count, 0);
    rst_n = 1'b1;

    // Branch hit followed by a two-instruction tail
    issue(I_BEQ); check("t1_d0", drop_instr, 0); check("t1_kc0", keep_cause, 3'b001);
    issue(I_ADD); check("t1_d1", drop_instr, 0); check("t1_kc1", keep_cause, 3'b010);
    issue(I_ADD); check("t1_d2", drop_instr, 0); check("t1_kc2", keep_cause, 3'b010);
    issue(I_ADD); check("t1_d3", drop_instr, 1);
    check("t1_kept", kept_count, 3); check("t1_dropped", dropped_count, 1);

    // Jump hits; a second hit reloads the tail
    cfg_class_en = 3'b010; cfg_tail_len = 4'd3;
    issue(I_JAL); issue(I_ADD); issue(I_CJ); issue(I_ADD); issue(I_ADD); issue(I_ADD);
    check("t2_last_kept", drop_instr, 0);
    issue(I_ADD); check("t2_end_drop", drop_instr, 1);

    // Event on channel 0 with no tail
    cfg_class_en = 3'b000; cfg_tail_len = 4'd0; cfg_evt_en = 2'b01;
    cnt[0] = cnt[0] + 1;
    idle(4);
    issue(I_ADD);
    check("t3_drop", drop_instr, 0); check("t3_kc", keep_cause, 3'b100); check("t3_ec", evt_cause, 2'b01);
    issue(I_ADD); check("t3_next_drop", drop_instr, 1);

    // Change on the consuming cycle stays pending; wrap counts as a change
    cfg_evt_en = 2'b11;
    cnt[1] = cnt[1] + 1; idle(1);
    cnt[1] = cnt[1] + 1; issue(I_ADD); check("t4_ec0", evt_cause, 2'b10);
    issue(I_ADD); check("t4_drop1", drop_instr, 0); check("t4_ec1", evt_cause, 2'b10);
    issue(I_ADD); check("t4_drop2", drop_instr, 1);
    cnt[1] = '1; idle(1); issue(I_ADD);
    cnt[1] = '0; idle(1); issue(I_ADD);
    check("t4_wrap_drop", drop_instr, 0); check("t4_wrap_ec", evt_cause, 2'b10);
    cfg_evt_en = 2'b00;

    // Modes and special classifications
    cfg_mode = 2'b01;
    repeat (3) begin issue(I_ADD); check("t5_pass", drop_instr, 0); end
    cfg_mode = 2'b10; cfg_class_en = 3'b001;
    issue(I_BEQ); check("t5_dropall", drop_instr, 1);
    cfg_mode = 2'b00; cfg_class_en = 3'b100;
    issue(I_WFI); check("t5_wfi", drop_instr, 0);
    cfg_class_en = 3'b010;
    issue(I_CJR0); check("t5_cjr_rs0", drop_instr, 1);
    issue(I_CJR); check("t5_cjr", drop_instr, 0);

    // Saturation of both statistics
    cfg_mode = 2'b01; repeat (300) issue(I_ADD);
    check("sat_kept", kept_count, STAT_MAX);
    cfg_mode = 2'b10; repeat (300) issue(I_ADD);
    check("sat_dropped", dropped_count, STAT_MAX);

    // Clear during an active tail, alone and coincident with pc_valid
    cfg_mode = 2'b00; cfg_tail_len = 4'd5;
    issue(I_JAL); issue(I_ADD);
    cfg_clear = 1'b1; idle(1);
    check("clr_kept", kept_count, 0); check("clr_dropped", dropped_count, 0);
    issue(I_ADD); check("clr_tail_gone", drop_instr, 1); check("clr_dropped1", dropped_count, 1);
    issue(I_JAL);
    cfg_clear = 1'b1; issue(I_ADD);
    check("clrpv_kept", drop_instr, 0); check("clrpv_stats", kept_count, 0);
    issue(I_ADD); check("clrpv_tail_gone", drop_instr, 1);

    // Reset mid-tail discards it
    issue(I_JAL);
    rst_n = 1'b0; idle(1);
    check("rst2_drop", drop_instr, 1); check("rst2_dropped", dropped_count, 0);
    rst_n = 1'b1;
    issue(I_ADD); check("rst2_no_tail", drop_instr, 1);

    // Randomized traffic against the model
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 31) == 0) begin
        cfg_mode     = 2'($urandom_range(0, 3));
        cfg_class_en = 3'($urandom);
        cfg_evt_en   = NUM_EVT'($urandom);
        cfg_tail_len = TAIL_WIDTH'($urandom);
      end
      for (int i = 0; i < NUM_EVT; i++) begin
        case ($urandom_range(0, 15))
          0: cnt[i] = cnt[i] + 1;
          1: cnt[i] = '1;
          2: cnt[i] = cnt[i] + CNT_WIDTH'($urandom_range(2, 100));
          default: ;
        endcase
      end
      cfg_clear  = ($urandom_range(0, 63) == 0);
      rst_n      = ($urandom_range(0, 199) != 0);
      pc_valid   = ($urandom_range(0, 3) != 0);
      next_instr = pick();
      step();
      rst_n = 1'b1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/trace_filter_prog.md
# trace_filter_prog

Runtime-programmable successor to the fixed-parameter trace filter in the continuous monitoring system. It classifies each valid retired instruction as branch, jump or WFI, and forwards a programmable-length tail of instructions after each hit. It detects increments on NUM_EVT HPM event counters, which generalises the fixed trap/interrupt pair. It produces a registered `drop_instr` qualifier with cause flags and saturating kept/dropped statistics for the trace storage path.

## Interface
- NUM_EVT, 2, number of monitored HPM event counters (1..16)
- CNT_WIDTH, 64, width of each event counter
- TAIL_WIDTH, 4, width of tail-length config and tail counter
- STAT_WIDTH, 32, width of statistics counters
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- pc_valid  in  1  next_instr is a valid retired instruction this cycle
- next_instr  in  32  instruction word; compressed instructions occupy [15:0]
- evt_counters  in  NUM_EVT*CNT_WIDTH  packed HPM counters; channel i at [i*CNT_WIDTH +: CNT_WIDTH]
- cfg_mode  in  2  00 filter, 01 pass-all, 10 drop-all, 11 treated as 00
- cfg_class_en  in  3  enable bits: bit0 branch, bit1 jump, bit2 WFI
- cfg_evt_en  in  NUM_EVT  per-channel event enable
- cfg_tail_len  in  TAIL_WIDTH  number of instructions kept after a class hit or event hit (0 = none)
- cfg_clear  in  1  one-cycle pulse; clears tail, pending events and statistics
- drop_instr  out  1  1 = drop the instruction qualified on the previous pc_valid cycle
- keep_cause  out  3  {event, tail, class}; valid when drop_instr=0
- evt_cause  out  NUM_EVT  channels consumed by the last kept instruction
- kept_count  out  STAT_WIDTH  saturating count of kept instructions
- dropped_count  out  STAT_WIDTH  saturating count of dropped instructions

## Operation
- Classification uses standard RV opcodes:
  - branch: [6:0]=1100011, or compressed quadrant 01 with [15:14]=11 (c.beqz/c.bnez).
  - jump: [6:0]=1101111 or 1100111; c.j/c.jal, which is quadrant 01 with funct3 101/001; or c.jr/c.jalr, which is quadrant 10 with [15:13]=100, rs1≠0, rs2=0.
  - WFI: exact match 32'h10500073.
  - class_hit is set when any enabled class matches.
- Tail counter tail_cnt (TAIL_WIDTH bits) is updated on each pc_valid:
  - If class_hit or event_hit and cfg_tail_len≠0, load cfg_tail_len. A reload restarts the tail and does not accumulate.
  - Otherwise, if tail_cnt≠0, decrement.
  - tail_active = (tail_cnt≠0) before the update.
- Event detection: prev_cnt[i] is registered every cycle, unconditionally.
  - When cnt[i]≠prev_cnt[i] and cfg_evt_en[i]=1, set evt_pend[i]. Wrap-around counts as a change.
  - event_hit = |evt_pend, sampled on pc_valid.
  - A pc_valid cycle consumes all pending bits.
  - If a new change is detected on the consuming cycle, that channel's bit stays set.
- Keep decision per pc_valid, mode 00: keep = class_hit | tail_active | event_hit. Mode 01: keep=1. Mode 10: keep=0.
  - In modes 01 and 10, tail and pending state still update, but causes read 0.
- Statistics:
  - On each pc_valid, increment kept_count or dropped_count.
  - Both saturate at all-ones.
- cfg_clear has the same effect on tail_cnt, evt_pend and the statistics as reset. It does not clear prev_cnt.
  - If cfg_clear coincides with pc_valid, the instruction is still qualified, using pre-clear state.
  - The statistics read 0 after the clear.
- Config changes take effect on the next pc_valid. Lowering cfg_tail_len does not truncate an active tail.

## Timing
- drop_instr, keep_cause, evt_cause and the statistics are registered.
- The decision for the instruction presented with pc_valid at cycle t appears at t+1.
- Outputs hold until the next pc_valid.
- Event latency: a counter change at cycle t sets evt_pend at t+1. A pc_valid at t+1 or later consumes it.
- Back-to-back pc_valid is supported with no bubbles.
- Reset values:
  - drop_instr=1
  - keep_cause=0
  - evt_cause=0
  - kept_count=0
  - dropped_count=0
  - tail_cnt=0
  - evt_pend=0
  - prev_cnt=evt_counters sampled during reset, so the first post-reset cycle sees no spurious event.
- Reset mid-tail or with events pending discards them. The first instruction after reset is judged on class only.

## Test plan
- Mode 00, class_en=3'b001, tail_len=2. Sequence: beq, add, add, add, each with pc_valid on consecutive cycles. Expected drop_instr: 0,0,0,1. keep_cause: 001,010,010, then don't-care. Expected counts: kept=3, dropped=1.
- tail_len=3. Sequence: jal, add, c.j, add, add, add, add. Expected drop: 0,0,0,0,0,0,1. The second hit reloads the tail.
- Event 0 enabled, tail_len=0. Bump counter 0 at cycle 5 with no pc_valid, then pc_valid add at cycle 9. Expected: drop=0, keep_cause=100, evt_cause=2'b01. The following add is dropped.
- Counter 1 changes in the same cycle that its pending bit is consumed. Expected: the next pc_valid instruction is also kept with evt_cause=2'b10. Also wrap counter 1 from all-ones to 0 and check it is detected.
- Modes:
  - Mode 01 with all adds: drop=0 for all.
  - Mode 10 with a branch: drop=1.
  - WFI 32'h10500073 with class_en bit2: kept.
  - c.jr with rs1=0: not classified as a jump.
- Preset stats near all-ones by long streams. Verify saturation. Then pulse cfg_clear during an active tail. Expected: tail aborted, counts 0. Assert rst_n=0 for 1 cycle: drop_instr=1.
